// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronises release of the board reset, holds all channels,
// then releases NUM_CH active-high channel resets one by one with a fixed stagger.
module reset_sequencer #(
  parameter int NUM_CH         = 4,
  parameter int HOLD_CYCLES    = 5,
  parameter int STAGGER_CYCLES = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int CNT_W          = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iRestart,
  output logic [NUM_CH-1:0] oChRst,
  output logic              oDone,
  output logic [7:0]        oLed
);

  typedef enum logic [1:0] {
    HOLD = 2'b01,
    REL  = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_END    = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] STAGGER_END = CNT_W'(STAGGER_CYCLES);
  localparam logic [4:0]       LAST_CH     = 5'(NUM_CH - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rst_n_sync;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [4:0]             rel_q, rel_d;
  logic [NUM_CH-1:0]      ch_rst_q, ch_rst_d;
  logic                   done_q, done_d;
  logic [7:0]             led_q, led_d;
  logic [1:0]             code_d;

  assign rst_n_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], 1'b1};
    state_d  = state_q;
    cnt_d    = cnt_q;
    rel_d    = rel_q;
    ch_rst_d = ch_rst_q;
    done_d   = done_q;
    cnt_inc  = cnt_q + CNT_W'(1);

    // The FSM only runs once the synchronised reset has been released; restart wins over any release.
    if (rst_n_sync) begin
      if (iRestart) begin
        state_d  = HOLD;
        cnt_d    = '0;
        rel_d    = '0;
        ch_rst_d = '1;
        done_d   = 1'b0;
      end else begin
        case (state_q)
          HOLD: begin
            if (cnt_inc == HOLD_END) begin
              ch_rst_d[0] = 1'b0;
              rel_d       = 5'd1;
              cnt_d       = '0;
              state_d     = (NUM_CH == 1) ? DONE : REL;
              done_d      = (NUM_CH == 1);
            end else begin
              cnt_d = cnt_inc;
            end
          end
          REL: begin
            if (cnt_inc == STAGGER_END) begin
              for (int i = 0; i < NUM_CH; i++) begin
                if (i == int'(rel_q)) ch_rst_d[i] = 1'b0;
              end
              rel_d = rel_q + 5'd1;
              cnt_d = '0;
              if (rel_q == LAST_CH) begin
                state_d = DONE;
                done_d  = 1'b1;
              end
            end else begin
              cnt_d = cnt_inc;
            end
          end
          DONE: begin
          end
          default: state_d = HOLD;
        endcase
      end
    end

    // Status code reads 00 until the synchroniser output is high on this edge.
    code_d = sync_d[SYNC_STAGES-1] ? 2'(state_d) : 2'b00;
    led_d  = {done_d, code_d, rel_d};
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync_q   <= '0;
      state_q  <= HOLD;
      cnt_q    <= '0;
      rel_q    <= '0;
      ch_rst_q <= '1;
      done_q   <= 1'b0;
      led_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rel_q    <= rel_d;
      ch_rst_q <= ch_rst_d;
      done_q   <= done_d;
      led_q    <= led_d;
    end
  end

  assign oChRst = ch_rst_q;
  assign oDone  = done_q;
  assign oLed   = led_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default-parameter instance A and a 1-channel corner instance B,
// each compared every cycle against a release-schedule model derived from elapsed cycles.
module tb_reset_sequencer;

  localparam int NA = 4, HA = 5, SA = 2;
  localparam int NB = 1, HB = 1, SB = 1;
  localparam int SYNC = 2;

  typedef struct packed {
    logic [7:0]  led;
    logic        done;
    logic [31:0] ch;
  } exp_t;

  logic        Clock;
  logic        Reset;
  logic        restartA, restartB;
  logic [NA-1:0] chRstA;
  logic [NB-1:0] chRstB;
  logic        doneA, doneB;
  logic [7:0]  ledA, ledB;

  int testsRun = 0;
  int testsFailed = 0;

  bit syncA, syncB;
  int hiA, hiB, kA, kB;

  reset_sequencer #(.NUM_CH(NA), .HOLD_CYCLES(HA), .STAGGER_CYCLES(SA), .SYNC_STAGES(SYNC), .CNT_W(8)) dutA (
    .Clock(Clock), .Reset(Reset), .iRestart(restartA),
    .oChRst(chRstA), .oDone(doneA), .oLed(ledA)
  );

  reset_sequencer #(.NUM_CH(NB), .HOLD_CYCLES(HB), .STAGGER_CYCLES(SB), .SYNC_STAGES(SYNC), .CNT_W(8)) dutB (
    .Clock(Clock), .Reset(Reset), .iRestart(restartB),
    .oChRst(chRstB), .oDone(doneB), .oLed(ledB)
  );

  initial Clock = 1'b0;
  always #10 Clock = ~Clock;

  // k counts edges since the schedule origin (T0 or the last restart edge).
  function automatic exp_t modelOut(bit synced, int k, int n, int h, int s);
    exp_t e;
    int rel;
    if (!synced) begin
      e.led  = 8'h00;
      e.done = 1'b0;
      e.ch   = '1;
      return e;
    end
    rel = (k < h) ? 0 : 1 + (k - h) / s;
    if (rel > n) rel = n;
    e.done = (rel == n);
    e.ch   = ~((32'd1 << rel) - 32'd1);
    e.led  = {e.done, e.done ? 2'b11 : ((rel == 0) ? 2'b01 : 2'b10), 5'(rel)};
    return e;
  endfunction

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      syncA = 1'b0; hiA = 0; kA = 0;
    end else if (!syncA) begin
      hiA++;
      if (hiA >= SYNC) begin syncA = 1'b1; kA = 0; end
    end else if (restartA) kA = 0;
    else if (kA < 100000) kA++;
  end

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      syncB = 1'b0; hiB = 0; kB = 0;
    end else if (!syncB) begin
      hiB++;
      if (hiB >= SYNC) begin syncB = 1'b1; kB = 0; end
    end else if (restartB) kB = 0;
    else if (kB < 100000) kB++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic ra, input logic rb);
    Reset    = rst;
    restartA = ra;
    restartB = rb;
  endtask

  always @(negedge Clock) begin
    exp_t eA, eB;
    eA = modelOut(syncA, kA, NA, HA, SA);
    eB = modelOut(syncB, kB, NB, HB, SB);
    checkOutput("A.oChRst", 32'(chRstA), eA.ch & 32'hF);
    checkOutput("A.oDone",  32'(doneA),  32'(eA.done));
    checkOutput("A.oLed",   32'(ledA),   32'(eA.led));
    checkOutput("B.oChRst", 32'(chRstB), eB.ch & 32'h1);
    checkOutput("B.oDone",  32'(doneB),  32'(eB.done));
    checkOutput("B.oLed",   32'(ledB),   32'(eB.led));
  end

  initial begin
    int hold;
    applyStimulus(1'b0, 1'b0, 1'b0);
    #100 applyStimulus(1'b1, 1'b0, 1'b0);

    // Power-up: first edge after release is still unsynchronised, second is T0.
    @(posedge Clock); #5;
    checkOutput("preT0.led", 32'(ledA), 32'h00);
    @(posedge Clock); #5;
    checkOutput("T0.led", 32'(ledA), 32'h20);
    checkOutput("T0.ch",  32'(chRstA), 32'hF);
    @(posedge Clock); #5;
    checkOutput("B.T0+1.ch",  32'(chRstB), 32'h0);
    checkOutput("B.T0+1.led", 32'(ledB), 32'hE1);
    repeat (4) @(posedge Clock); #5;
    checkOutput("T0+5.ch",  32'(chRstA), 32'hE);
    checkOutput("T0+5.led", 32'(ledA), 32'h41);
    repeat (6) @(posedge Clock); #5;
    checkOutput("T0+11.ch",   32'(chRstA), 32'h0);
    checkOutput("T0+11.led",  32'(ledA), 32'hE4);
    checkOutput("T0+11.done", 32'(doneA), 32'h1);

    // Restart while in DONE.
    repeat (2) @(posedge Clock); #3 applyStimulus(1'b1, 1'b1, 1'b0);
    @(posedge Clock); #3 applyStimulus(1'b1, 1'b0, 1'b0);
    #2;
    checkOutput("Tr.led", 32'(ledA), 32'h20);
    checkOutput("Tr.ch",  32'(chRstA), 32'hF);
    repeat (5) @(posedge Clock); #5;
    checkOutput("Tr+5.ch", 32'(chRstA), 32'hE);
    repeat (8) @(posedge Clock);

    // Async assertion, then release 2 ns before an edge.
    #4 applyStimulus(1'b0, 1'b0, 1'b0);
    #2 checkOutput("async.led", 32'(ledA), 32'h00);
    repeat (2) @(posedge Clock);
    #18 applyStimulus(1'b1, 1'b0, 1'b0);
    @(posedge Clock); #5;
    checkOutput("sync.edge1.code", 32'(ledA[6:5]), 32'h0);
    @(posedge Clock); #5;
    checkOutput("sync.T0.code", 32'(ledA[6:5]), 32'h1);

    // Restart on the same edge as the scheduled ch1 release.
    repeat (6) @(posedge Clock);
    #3 applyStimulus(1'b1, 1'b1, 1'b0);
    @(posedge Clock); #3 applyStimulus(1'b1, 1'b0, 1'b0);
    #2 checkOutput("midRel.ch", 32'(chRstA), 32'hF);
    repeat (5) @(posedge Clock); #5;
    checkOutput("midRel.T0+12.ch", 32'(chRstA), 32'hE);

    // Async reset while releasing, then full replay.
    @(posedge Clock); #3;
    checkOutput("preAsync.code", 32'(ledA[6:5]), 32'h2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("asyncRel.ch",   32'(chRstA), 32'hF);
    checkOutput("asyncRel.done", 32'(doneA), 32'h0);
    checkOutput("asyncRel.led",  32'(ledA), 32'h00);
    repeat (3) @(posedge Clock); #7 applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge Clock); #5;
    checkOutput("replay.T0.led", 32'(ledA), 32'h20);
    repeat (11) @(posedge Clock); #5;
    checkOutput("replay.T0+11.led", 32'(ledA), 32'hE4);

    // Restart held high on the single-channel instance.
    @(posedge Clock); #3 applyStimulus(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(posedge Clock); #5;
      checkOutput("B.held.ch",   32'(chRstB), 32'h1);
      checkOutput("B.held.done", 32'(doneB), 32'h0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(posedge Clock); #5;
    checkOutput("B.afterHold.ch", 32'(chRstB), 32'h0);

    // Randomised restarts and async resets.
    for (int c = 0; c < 400; c++) begin
      @(posedge Clock); #3;
      applyStimulus(1'b1, ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 59) == 0) begin
        hold = $urandom_range(1, 4);
        #($urandom_range(1, 5)) Reset = 1'b0;
        repeat (hold) @(posedge Clock);
        #($urandom_range(12, 18)) Reset = 1'b1;
      end
    end
    @(posedge Clock); #3 applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (30) @(posedge Clock);
    #5;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised, synthesizable successor to the bench-level reset stimulus used around `MiniAlu`.

- **Where it sits:** between the board clock/reset pins and the design's sub-blocks.
- **What it does:** synchronises the deassertion of the external active-low reset, holds every channel in reset for a programmable interval, then releases `NUM_CH` active-high channel resets one at a time with a programmable stagger.
- **Extras:** a software/debug restart request re-runs the full sequence, and an 8-bit LED status word exposes progress.

## Interface

Parameters
- `NUM_CH`, default 4: number of reset channels. Legal range 1..31.
- `HOLD_CYCLES`, default 5: cycles all channels stay asserted before channel 0 is released. Must be ≥1.
- `STAGGER_CYCLES`, default 2: cycles between consecutive channel releases. Must be ≥1.
- `SYNC_STAGES`, default 2: flops in the reset-deassertion synchroniser. Must be ≥2.
- `CNT_W`, default 8: width of the interval counter. Must hold max(`HOLD_CYCLES`, `STAGGER_CYCLES`).

Ports
- `Clock`  in  1  single clock; all state updates on rising edge.
- `Reset`  in  1  asynchronous, active-low reset. Assertion takes effect immediately; deassertion passes through the synchroniser.
- `iRestart`  in  1  synchronous restart request, sampled on every rising edge.
- `oChRst`  out  NUM_CH  active-high reset per channel; bit i drives sub-block i.
- `oDone`  out  1  high when all channels are released.
- `oLed`  out  8  status word: `[7]`=`oDone`, `[6:5]`=state code, `[4:0]`=count of released channels.

## Operation

- **Reset synchroniser:** `SYNC_STAGES`-deep chain of flops. It clears asynchronously when `Reset`=0 and shifts in 1 while `Reset`=1. Its output `rst_n_sync` gates the FSM.
- **Behaviour while `Reset`=0 or `rst_n_sync`=0:**
  - `oChRst` = all ones, `oDone`=0, `oLed`=8'h00.
  - FSM is held in HOLD, counters are zero.
- **FSM states and codes:** HOLD (01), REL (10), DONE (11). Code 00 appears on `oLed[6:5]` only while `rst_n_sync`=0.
- **HOLD:**
  - All `oChRst` bits are 1 and the interval counter increments.
  - On reaching `HOLD_CYCLES`: clear `oChRst[0]`, set released count to 1, counter to 0.
  - Next state is REL, or DONE if `NUM_CH`=1.
- **REL:**
  - The counter increments.
  - On reaching `STAGGER_CYCLES`: clear the next channel bit in ascending index order, increment the released count, counter to 0.
  - When the last channel is released, go to DONE and set `oDone` on the same edge.
- **DONE:** outputs are static; `oChRst` = all zeros.
- **Restart:** `iRestart`=1 sampled in any state with `rst_n_sync`=1 takes effect on that edge:
  - all `oChRst` return to 1, `oDone`=0, released count=0, counter=0, state=HOLD.
  - Restart has priority over any release scheduled on the same edge.
- **Restart held high:** every edge restarts, so channels remain in reset until `iRestart` drops.
- **Reset mid-sequence:** `Reset`=0 in any state asynchronously forces the reset values above. The sequence starts again from HOLD after resynchronisation.
- **Monotonic release:** once released, a channel bit never re-asserts except by restart or `Reset`.
- **Outputs registered:** all outputs come from flops; there is no combinational path from inputs to outputs.

## Timing

- **T0:** the rising edge at which `rst_n_sync` first samples 1. This is the `SYNC_STAGES`-th rising edge after `Reset` rises, given `Reset` meets setup to that edge.
- **Release times:** `oChRst[i]` falls at edge T0 + `HOLD_CYCLES` + i·`STAGGER_CYCLES`.
- **Done time:** `oDone` rises at edge T0 + `HOLD_CYCLES` + (`NUM_CH`−1)·`STAGGER_CYCLES`.
- **Restart timing:** a restart sampled at edge Tr reproduces the same schedule with Tr in place of T0.
- **Default parameters:** NUM_CH=4, HOLD=5, STAGGER=2, SYNC=2.
  - Releases at T0+5, T0+7, T0+9, T0+11.
  - `oDone` at T0+11.
- **Reset assertion:** asynchronous. Outputs reach their reset values within propagation delay, with no clock required.

## Test plan

- **Power-up sequence (defaults):** 20 ns clock; `Reset`=0 for 100 ns, then 1 → `oChRst`=4'b1111 until T0+5, then 1110@T0+5, 1100@T0+7, 1000@T0+9, 0000@T0+11. `oDone`=1 and `oLed`=8'hE4 at T0+11.
- **Synchroniser latency:** `Reset` rises 2 ns before an edge → T0 is the second following edge. `oLed[6:5]`=00 before T0 and 01 from T0.
- **Restart in DONE:** one-cycle `iRestart` pulse at Tr → at Tr `oChRst`=1111, `oDone`=0, `oLed`=8'h20. Releases then follow at Tr+5/7/9/11.
- **Restart mid-release:** `iRestart` on the same edge as the scheduled ch1 release (T0+7) → ch1 is not released, `oChRst`=1111 at T0+7. Ch0 is next released at T0+12.
- **Async reset mid-REL:** drive `Reset`=0 at T0+8 between edges → `oChRst`=1111, `oDone`=0, `oLed`=00 before the next edge. The full sequence replays after `Reset` returns to 1.
- **Parameter corner:** NUM_CH=1, HOLD=1, STAGGER=1 → `oChRst` falls and `oDone` rises at T0+1. `iRestart` held high for 10 cycles keeps `oChRst`=1 throughout.
